// File: rtl/sobel_linebuf_ctrl.sv
// Line-buffer sequencer for a Sobel 3x3 window: drives two external show-ahead FIFOs
// as a 2-line delay and emits one vertically aligned top/mid/bot column per accepted pixel.
module sobel_linebuf_ctrl #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_data,
  output logic              f0_wr_en,
  output logic [DATA_W-1:0] f0_din,
  output logic              f0_rd_en,
  input  logic [DATA_W-1:0] f0_dout,
  input  logic              f0_empty,
  output logic              f1_wr_en,
  output logic [DATA_W-1:0] f1_din,
  output logic              f1_rd_en,
  input  logic [DATA_W-1:0] f1_dout,
  input  logic              f1_empty,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_top,
  output logic [DATA_W-1:0] tap_mid,
  output logic [DATA_W-1:0] tap_bot,
  output logic              tap_eol,
  output logic              tap_eof,
  output logic [1:0]        err
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, ROW0, ROW1, RUN, FLUSH} state_t;

  state_t           state_reg, state_next, eff_state;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic [COL_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic [1:0]       err_reg, err_next;
  logic             accept, proc, last_col, last_row;

  logic              tap_valid_reg, tap_eol_reg, tap_eof_reg;
  logic [DATA_W-1:0] tap_top_reg, tap_mid_reg, tap_bot_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      col_reg       <= '0;
      row_reg       <= '0;
      flush_cnt_reg <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      flush_cnt_reg <= flush_cnt_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    in_ready       = (state_reg != FLUSH);
    accept         = in_valid & in_ready;
    // A start-of-frame pixel seen in IDLE is handled exactly like a ROW0 pixel.
    eff_state      = (state_reg == IDLE && in_sof) ? ROW0 : state_reg;
    proc           = accept && (eff_state != IDLE);
    last_col       = (col_reg == COL_LAST);
    last_row       = (row_reg == ROW_LAST);
    state_next     = state_reg;
    col_next       = col_reg;
    row_next       = row_reg;
    flush_cnt_next = flush_cnt_reg;
    f0_wr_en       = 1'b0;
    f0_rd_en       = 1'b0;
    f1_wr_en       = 1'b0;
    f1_rd_en       = 1'b0;
    f0_din         = in_data;
    f1_din         = f0_dout;

    case (eff_state)
      ROW0: f0_wr_en = proc;
      ROW1: begin
        f0_wr_en = proc;
        f0_rd_en = proc;
        f1_wr_en = proc;
      end
      RUN: begin
        f0_wr_en = proc;
        f0_rd_en = proc;
        f1_wr_en = proc;
        f1_rd_en = proc;
      end
      FLUSH: begin
        f0_rd_en       = 1'b1;
        f1_rd_en       = 1'b1;
        flush_cnt_next = flush_cnt_reg + COL_W'(1);
        if (flush_cnt_reg == COL_LAST) begin
          state_next     = IDLE;
          flush_cnt_next = '0;
          col_next       = '0;
          row_next       = '0;
        end
      end
      default: ;
    endcase

    if (proc) begin
      state_next = eff_state;
      if (last_col) begin
        col_next = '0;
        row_next = row_reg + ROW_W'(1);
        case (eff_state)
          ROW0: state_next = ROW1;
          ROW1: state_next = RUN;
          RUN: if (last_row) begin
            state_next = FLUSH;
            row_next   = '0;
          end
          default: ;
        endcase
      end else begin
        col_next = col_reg + COL_W'(1);
      end
    end

    err_next    = err_reg;
    err_next[0] = err_reg[0] | (accept & in_sof & (state_reg != IDLE));
    err_next[1] = err_reg[1] | (f0_rd_en & f0_empty) | (f1_rd_en & f1_empty);
  end

  // Taps capture the column as it stood in the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_valid_reg <= 1'b0;
      tap_eol_reg   <= 1'b0;
      tap_eof_reg   <= 1'b0;
      tap_top_reg   <= '0;
      tap_mid_reg   <= '0;
      tap_bot_reg   <= '0;
    end else begin
      tap_valid_reg <= proc && (eff_state == RUN);
      tap_eol_reg   <= proc && (eff_state == RUN) && last_col;
      tap_eof_reg   <= proc && (eff_state == RUN) && last_col && last_row;
      if (proc) begin
        tap_bot_reg <= in_data;
        tap_mid_reg <= f0_dout;
        tap_top_reg <= f1_dout;
      end
    end
  end

  assign tap_valid = tap_valid_reg;
  assign tap_eol   = tap_eol_reg;
  assign tap_eof   = tap_eof_reg;
  assign tap_top   = tap_top_reg;
  assign tap_mid   = tap_mid_reg;
  assign tap_bot   = tap_bot_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// Bench for sobel_linebuf_ctrl: behavioural show-ahead FIFOs plus a frame-level tap model
// (each tap = pixel two rows up, one row up, current) compared against observed taps.
module tb_sobel_linebuf_ctrl;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en, f0_empty, f1_empty;
  logic [DW-1:0] f0_din, f0_dout, f1_din, f1_dout;
  logic          tap_valid, tap_eol, tap_eof;
  logic [DW-1:0] tap_top, tap_mid, tap_bot;
  logic [1:0]    err;
  logic          force_f0_empty = 1'b0;

  int n_chk = 0, n_fail = 0, cyc = 0, ready_low = 0;
  logic [DW-1:0] pix [N];
  int            acc_q[$];
  logic [63:0]   got_q[$], exp_q[$];

  sobel_linebuf_ctrl #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .f0_wr_en(f0_wr_en), .f0_din(f0_din), .f0_rd_en(f0_rd_en),
    .f0_dout(f0_dout), .f0_empty(f0_empty), .f1_wr_en(f1_wr_en), .f1_din(f1_din),
    .f1_rd_en(f1_rd_en), .f1_dout(f1_dout), .f1_empty(f1_empty), .tap_valid(tap_valid),
    .tap_top(tap_top), .tap_mid(tap_mid), .tap_bot(tap_bot), .tap_eol(tap_eol),
    .tap_eof(tap_eof), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Show-ahead FIFO models, reset from the same rst as the controller
  logic [DW-1:0] f0_mem [8], f1_mem [8];
  logic [2:0]    f0_rp, f0_wp, f1_rp, f1_wp;
  logic [3:0]    f0_cnt, f1_cnt;
  wire           f0_pop = f0_rd_en && (f0_cnt != 0);
  wire           f1_pop = f1_rd_en && (f1_cnt != 0);
  assign f0_dout  = f0_mem[f0_rp];
  assign f1_dout  = f1_mem[f1_rp];
  assign f0_empty = (f0_cnt == 0) || force_f0_empty;
  assign f1_empty = (f1_cnt == 0);

  always @(posedge clk) begin
    if (rst) begin
      f0_rp <= '0; f0_wp <= '0; f0_cnt <= '0;
      f1_rp <= '0; f1_wp <= '0; f1_cnt <= '0;
    end else begin
      if (f0_pop) f0_rp <= f0_rp + 3'd1;
      if (f1_pop) f1_rp <= f1_rp + 3'd1;
      if (f0_wr_en) begin f0_mem[f0_wp] <= f0_din; f0_wp <= f0_wp + 3'd1; end
      if (f1_wr_en) begin f1_mem[f1_wp] <= f1_din; f1_wp <= f1_wp + 3'd1; end
      f0_cnt <= f0_cnt + 4'(f0_wr_en) - 4'(f0_pop);
      f1_cnt <= f1_cnt + 4'(f1_wr_en) - 4'(f1_pop);
    end
  end

  always @(negedge clk) begin
    if (tap_valid) got_q.push_back({32'(cyc), 6'b0, tap_eol, tap_eof, tap_top, tap_mid, tap_bot});
    if (!rst && !in_ready) ready_low++;
  end

  // Expected taps of one frame: rows 2..H-1, tap visible in the cycle after acceptance
  task automatic build_exp(input int base);
    for (int i = 2 * W; i < N; i++)
      exp_q.push_back({32'(acc_q[base + i]), 6'b0, (i % W) == W - 1, i == N - 1,
                       pix[i - 2 * W], pix[i - W], pix[i]});
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete(); acc_q.delete(); exp_q.delete(); ready_low = 0;
  endtask

  task automatic drive_pixel(input logic [DW-1:0] d, input logic sof, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d; in_sof = sof; waited = 0;
    while (!in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    n_chk++;
    if (waited >= 50) begin
      n_fail++;
      $display("FAIL in_ready_timeout got in_ready=%0b required 1 within 50 cycles", in_ready);
    end
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // gap_mode: 0 none, 1 alternate, 2 random 0..2; extra_sof: index receiving a stray in_sof
  task automatic send_frame(input int gap_mode, input int extra_sof);
    int gap;
    for (int i = 0; i < N; i++) begin
      gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      drive_pixel(pix[i], (i == 0) || (i == extra_sof), gap);
    end
  endtask

  task automatic rand_pix();
    for (int i = 0; i < N; i++) pix[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_chk++; if (tap_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tap_valid got %b required 0", tap_valid); end
    n_chk++; if ({tap_top, tap_mid, tap_bot} !== 24'h0) begin n_fail++; $display("FAIL rst_taps got %h required 0", {tap_top, tap_mid, tap_bot}); end
    n_chk++; if ({tap_eol, tap_eof, err} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b required 0000", {tap_eol, tap_eof, err}); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    n_chk++; if ({f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en} !== 4'b0) begin n_fail++; $display("FAIL rst_fifo_ctl got %b required 0000", {f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en}); end
  endtask

  task automatic test_basic_frame();
    logic [63:0] g;
    do_reset();
    for (int i = 0; i < N; i++) pix[i] = DW'(i);
    send_frame(0, -1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t1_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t1_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL t1_err got %b required 00", err); end
  endtask

  task automatic test_stall();
    logic [63:0] g;
    do_reset();
    rand_pix();
    send_frame(1, -1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t2_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t2_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] g;
    do_reset();
    rand_pix();
    send_frame(0, -1);
    send_frame(2, -1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    build_exp(N);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t3_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t3_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
    n_chk++; if (ready_low != 2 * W) begin n_fail++; $display("FAIL t3_flush_cycles got %0d required %0d", ready_low, 2 * W); end
    n_chk++; if (f0_cnt != 0 || f1_cnt != 0) begin n_fail++; $display("FAIL t3_fifo_empty got %0d/%0d required 0/0", f0_cnt, f1_cnt); end
  endtask

  task automatic test_idle_drop();
    logic [63:0] g;
    do_reset();
    for (int k = 0; k < 3; k++) drive_pixel(DW'($urandom_range(0, 255)), 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    n_chk++; if (got_q.size() != 0) begin n_fail++; $display("FAIL t4_drop_taps got %0d required 0", got_q.size()); end
    n_chk++; if (err !== 2'b00 || f0_cnt != 0) begin n_fail++; $display("FAIL t4_drop_state got err=%b f0=%0d required err=00 f0=0", err, f0_cnt); end
    acc_q.delete();
    rand_pix();
    send_frame(0, -1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t4_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t4_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_stray_sof();
    logic [63:0] g;
    do_reset();
    rand_pix();
    send_frame(0, 2 * W + 1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    n_chk++; if (err !== 2'b01) begin n_fail++; $display("FAIL t5_err got %b required 01", err); end
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t5_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] g;
    do_reset();
    rand_pix();
    for (int i = 0; i < 2 * W + 2; i++) drive_pixel(pix[i], i == 0, 0);
    in_valid = 1'b1; in_data = pix[2 * W + 2]; rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (tap_valid !== 1'b0) begin n_fail++; $display("FAIL t6_tap_valid got %b required 0", tap_valid); end
    n_chk++; if (in_ready !== 1'b1 || err !== 2'b00) begin n_fail++; $display("FAIL t6_state got ready=%b err=%b required 1/00", in_ready, err); end
    rst = 1'b0; in_valid = 1'b0;
    got_q.delete(); acc_q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) pix[i] = DW'(i);
    send_frame(0, -1);
    repeat (W + 3) @(posedge clk); #1;
    build_exp(0);
    n_chk++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t6_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 64'hx;
      n_chk++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL t6_tap%0d got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    force_f0_empty = 1'b1;
    rand_pix();
    for (int i = 0; i < W; i++) drive_pixel(pix[i], i == 0, 0);
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL uf_before_read got %b required 00", err); end
    drive_pixel(pix[W], 1'b0, 0);
    force_f0_empty = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_chk++; if (err !== 2'b10) begin n_fail++; $display("FAIL uf_sticky got %b required 10", err); end
    do_reset();
    n_chk++; if (err !== 2'b00) begin n_fail++; $display("FAIL uf_cleared got %b required 00", err); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_back_to_back();
    test_idle_drop();
    test_stray_sof();
    test_mid_reset();
    test_underflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
